// File: rtl/rat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : rat_pkg                                                    |
// | Brief   : Shared constants and types for the RAT CPU next-PC logic.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package rat_pkg;

    // Program counter width.
    localparam int AW = 10;

    // Interrupt service routine entry address.
    localparam logic [AW-1:0] INTR_VEC = 10'h3FF;

    // Selected next-PC source for the current cycle.
    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_CALL   = 3'd2,
        SRC_RET    = 3'd3,
        SRC_RETI   = 3'd4,
        SRC_INTR   = 3'd5
    } pc_src_t;

endpackage
`default_nettype wire

// File: rtl/rs_lifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rs_lifo                                                    |
// | Brief   : Return-address LIFO. Saturating pointer, no overwrite of   |
// |           the oldest entries, no bypass from push to top.            |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rs_lifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            push_data,
    output logic [AW-1:0]            top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] C_FULL = PW'(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_do_push;
    logic          w_do_pop;

    // Pointer is the occupancy; the write slot is the pointer, the top is one below.
    always_comb begin
        full      = (r_ptr == C_FULL);
        empty     = (r_ptr == '0);
        w_wr_idx  = r_ptr[IW-1:0];
        w_rd_idx  = w_wr_idx - IW'(1);
        w_do_push = push && !full;
        w_do_pop  = pop && !empty && !push;
        depth     = r_ptr;
        top       = empty ? '0 : r_mem[w_rd_idx];
    end

    // Occupancy pointer: saturates at both ends, never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_do_push) begin
            r_ptr <= r_ptr + PW'(1);
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - PW'(1);
        end
    end

    // Storage write; contents need no reset since the pointer gates every read.
    always_ff @(posedge clk) begin
        if (rst_n && w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_ret_stack                                               |
// | Brief   : Next-PC source stage: selects branch/call/return/RETI/     |
// |           interrupt target, drives the PC load strobe, and keeps the |
// |           return-address stack plus interrupt-active state.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pc_ret_stack
    import rat_pkg::*;
#(
    parameter int              DEPTH    = 8,
    parameter int              AW       = rat_pkg::AW,
    parameter logic [AW-1:0]   INTR_VEC = AW'(rat_pkg::INTR_VEC)
) (
    input  logic                     RS_CLK,
    input  logic                     RS_RST_N,
    input  logic [AW-1:0]            RS_PC_COUNT,
    input  logic [AW-1:0]            RS_IMM,
    input  logic                     RS_BRANCH,
    input  logic                     RS_CALL,
    input  logic                     RS_RET,
    input  logic                     RS_RETI,
    input  logic                     RS_INTR,
    output logic                     RS_PC_LD,
    output logic [AW-1:0]            RS_PC_DIN,
    output logic                     RS_INT_ACK,
    output logic [$clog2(DEPTH):0]   RS_DEPTH,
    output logic                     RS_OVF,
    output logic                     RS_UNF
);

    pc_src_t       w_src;
    logic          r_int_active;
    logic          r_ovf;
    logic          r_unf;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_push_data;
    logic [AW-1:0] w_top;
    logic          w_full;
    logic          w_empty;

    // Priority encoder; reset masks every request.
    always_comb begin
        w_src = SRC_NONE;
        if (!RS_RST_N)                      w_src = SRC_NONE;
        else if (RS_INTR && !r_int_active)  w_src = SRC_INTR;
        else if (RS_RETI)                   w_src = SRC_RETI;
        else if (RS_RET)                    w_src = SRC_RET;
        else if (RS_CALL)                   w_src = SRC_CALL;
        else if (RS_BRANCH)                 w_src = SRC_BRANCH;
    end

    // Output and stack-control mux keyed off the selected source.
    always_comb begin
        RS_PC_LD    = 1'b0;
        RS_PC_DIN   = '0;
        RS_INT_ACK  = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_push_data = '0;
        case (w_src)
            SRC_INTR: begin
                // The interrupted instruction has not run yet, so resume at it.
                RS_PC_LD    = 1'b1;
                RS_PC_DIN   = INTR_VEC;
                RS_INT_ACK  = 1'b1;
                w_push      = 1'b1;
                w_push_data = RS_PC_COUNT;
            end
            SRC_CALL: begin
                RS_PC_LD    = 1'b1;
                RS_PC_DIN   = RS_IMM;
                w_push      = 1'b1;
                w_push_data = RS_PC_COUNT + AW'(1);
            end
            SRC_RET, SRC_RETI: begin
                // Empty stack: no load, so the counter simply increments.
                RS_PC_LD  = !w_empty;
                RS_PC_DIN = w_empty ? '0 : w_top;
                w_pop     = !w_empty;
            end
            SRC_BRANCH: begin
                RS_PC_LD  = 1'b1;
                RS_PC_DIN = RS_IMM;
            end
            default: ;
        endcase
    end

    // Interrupt-active flag and sticky overflow/underflow flags.
    always_ff @(posedge RS_CLK) begin
        if (!RS_RST_N) begin
            r_int_active <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else begin
            if (w_src == SRC_INTR)      r_int_active <= 1'b1;
            else if (w_src == SRC_RETI) r_int_active <= 1'b0;
            if (w_push && w_full)       r_ovf <= 1'b1;
            if ((w_src == SRC_RET || w_src == SRC_RETI) && w_empty) r_unf <= 1'b1;
        end
    end

    assign RS_OVF = r_ovf;
    assign RS_UNF = r_unf;

    rs_lifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_lifo (
        .clk       (RS_CLK),
        .rst_n     (RS_RST_N),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_push_data),
        .top       (w_top),
        .depth     (RS_DEPTH),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_pc_ret_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_pc_ret_stack                                            |
// | Brief   : Scoreboard bench for pc_ret_stack with directed vectors.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_pc_ret_stack;

    logic       clk;
    logic       rst_n;
    logic [9:0] pc;
    logic [9:0] imm;
    logic       br, call, ret, reti, intr;
    logic       ld;
    logic [9:0] din;
    logic       ack;
    logic [3:0] dep;
    logic       ovf, unf;

    typedef struct {
        string      name;
        logic       ld;
        logic [9:0] din;
        logic       ack;
        logic [3:0] dep;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    pc_ret_stack #(.DEPTH(8), .AW(10), .INTR_VEC(10'h3FF)) dut (
        .RS_CLK      (clk),
        .RS_RST_N    (rst_n),
        .RS_PC_COUNT (pc),
        .RS_IMM      (imm),
        .RS_BRANCH   (br),
        .RS_CALL     (call),
        .RS_RET      (ret),
        .RS_RETI     (reti),
        .RS_INTR     (intr),
        .RS_PC_LD    (ld),
        .RS_PC_DIN   (din),
        .RS_INT_ACK  (ack),
        .RS_DEPTH    (dep),
        .RS_OVF      (ovf),
        .RS_UNF      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs just after a rising edge and queue the expectation.
    task automatic step(input string nm, input logic rn, input logic b, input logic c,
                        input logic r, input logic ri, input logic it,
                        input logic [9:0] p, input logic [9:0] im,
                        input logic eld, input logic [9:0] edin, input logic eack,
                        input logic [3:0] edep, input logic eovf, input logic eunf);
        exp_t e;
        rst_n = rn; br = b; call = c; ret = r; reti = ri; intr = it; pc = p; imm = im;
        e.name = nm; e.ld = eld; e.din = edin; e.ack = eack;
        e.dep = edep; e.ovf = eovf; e.unf = eunf;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are settled mid-cycle, compare against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (ld !== e.ld || din !== e.din || ack !== e.ack ||
                dep !== e.dep || ovf !== e.ovf || unf !== e.unf) begin
                errors++;
                $display("FAIL %s: got ld=%0b din=%h ack=%0b dep=%0d ovf=%0b unf=%0b, expected ld=%0b din=%h ack=%0b dep=%0d ovf=%0b unf=%0b",
                         e.name, ld, din, ack, dep, ovf, unf,
                         e.ld, e.din, e.ack, e.dep, e.ovf, e.unf);
            end
        end
    end

    initial begin
        rst_n = 1'b0; br = 0; call = 0; ret = 0; reti = 0; intr = 0; pc = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        //     name          rn b c r ri it  pc      imm      ld din     ack dep ovf unf
        step("reset_hold",   0, 0,1,0,0,0, 10'h010, 10'h100, 0, 10'h000, 0, 0, 0, 0);
        step("call1",        1, 0,1,0,0,0, 10'h010, 10'h100, 1, 10'h100, 0, 0, 0, 0);
        step("ret1",         1, 0,0,1,0,0, 10'h000, 10'h000, 1, 10'h011, 0, 1, 0, 0);
        step("intr1",        1, 0,0,0,0,1, 10'h020, 10'h000, 1, 10'h3FF, 1, 0, 0, 0);
        step("intr_held",    1, 0,0,0,0,1, 10'h3FF, 10'h000, 0, 10'h000, 0, 1, 0, 0);
        step("reti1",        1, 0,0,0,1,1, 10'h200, 10'h000, 1, 10'h020, 0, 1, 0, 0);
        step("intr2",        1, 0,0,0,0,1, 10'h030, 10'h000, 1, 10'h3FF, 1, 0, 0, 0);
        step("reti2",        1, 0,0,0,1,0, 10'h000, 10'h000, 1, 10'h030, 0, 1, 0, 0);
        step("branch",       1, 1,0,0,0,0, 10'h000, 10'h155, 1, 10'h155, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            step($sformatf("call_fill%0d", i), 1, 0,1,0,0,0, 10'h040 + 10'(i), 10'h100 + 10'(i),
                 1, 10'h100 + 10'(i), 0, (i < 8) ? 4'(i) : 4'd8, 0, 0);
        step("ovf_seen",     1, 0,0,0,0,0, 10'h000, 10'h000, 0, 10'h000, 0, 8, 1, 0);
        for (int i = 0; i < 8; i++)
            step($sformatf("ret_drain%0d", i), 1, 0,0,1,0,0, 10'h000, 10'h000,
                 1, 10'h048 - 10'(i), 0, 4'(8 - i), 1, 0);
        step("ret_empty",    1, 0,0,1,0,0, 10'h000, 10'h000, 0, 10'h000, 0, 0, 1, 0);
        step("unf_sticky",   1, 1,0,0,0,0, 10'h000, 10'h0AA, 1, 10'h0AA, 0, 0, 1, 1);
        step("combo_intr",   1, 1,0,1,0,1, 10'h123, 10'h2AA, 1, 10'h3FF, 1, 0, 1, 1);
        step("call_wrap",    1, 0,1,0,0,0, 10'h3FF, 10'h050, 1, 10'h050, 0, 1, 1, 1);
        step("ret_wrap",     1, 0,0,1,0,0, 10'h000, 10'h000, 1, 10'h000, 0, 2, 1, 1);
        step("reti_combo",   1, 0,0,0,1,0, 10'h000, 10'h000, 1, 10'h123, 0, 1, 1, 1);
        step("fill_a",       1, 0,1,0,0,0, 10'h060, 10'h070, 1, 10'h070, 0, 0, 1, 1);
        step("fill_b",       1, 0,1,0,0,0, 10'h061, 10'h070, 1, 10'h070, 0, 1, 1, 1);
        step("fill_c",       1, 0,1,0,0,0, 10'h062, 10'h070, 1, 10'h070, 0, 2, 1, 1);
        step("rst_mid",      0, 0,1,0,0,0, 10'h063, 10'h070, 0, 10'h000, 0, 3, 1, 1);
        step("post_rst",     0, 0,0,0,0,0, 10'h000, 10'h000, 0, 10'h000, 0, 0, 0, 0);
        step("intr_after",   1, 0,0,0,0,1, 10'h010, 10'h000, 1, 10'h3FF, 1, 0, 0, 0);
        rst_n = 1'b1; br = 0; call = 0; ret = 0; reti = 0; intr = 0;
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
